// File: rtl/result_display_ctrl_pkg.sv
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared types and constants for the result display controller.
//             state_t enumerates the progress states; the localparams fix the
//             digit count, the error glyph nibble and the largest legal class.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        SHOW = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int         NUM_DIGITS = 6;
    localparam logic [3:0] NIB_ERR    = 4'hE;
    localparam logic [3:0] MAX_CLASS  = 4'd9;

endpackage

`default_nettype wire

// File: rtl/result_display_ctrl_if.sv
// ============================================================================
//  Module   : result_display_ctrl_if
//  Purpose  : Bundles the inference handshake inputs and the digit-driver
//             outputs of result_display_ctrl.
//  Ports    : start_i, result_valid_i, result_class_i[3:0],
//             result_score_i[15:0], clear_i        (towards the controller)
//             digit_nib_o[23:0], digit_dash_o[5:0],
//             busy_o, timeout_o                    (from the controller)
//  Modports : master - stimulus/consumer side, slave - controller side
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface result_display_ctrl_if;
    import display_pkg::*;

    logic                        start_i;
    logic                        result_valid_i;
    logic [3:0]                  result_class_i;
    logic [15:0]                 result_score_i;
    logic                        clear_i;
    logic [4*NUM_DIGITS-1:0]     digit_nib_o;
    logic [NUM_DIGITS-1:0]       digit_dash_o;
    logic                        busy_o;
    logic                        timeout_o;

    modport master (
        output start_i, result_valid_i, result_class_i, result_score_i, clear_i,
        input  digit_nib_o, digit_dash_o, busy_o, timeout_o
    );

    modport slave (
        input  start_i, result_valid_i, result_class_i, result_score_i, clear_i,
        output digit_nib_o, digit_dash_o, busy_o, timeout_o
    );

endinterface

`default_nettype wire

// File: rtl/result_display_ctrl_tick_counter.sv
// ============================================================================
//  Module   : tick_counter
//  Purpose  : Free-running modulo-N counter with enable and synchronous clear.
//             tick_o pulses for one cycle while the counter sits at N-1 and is
//             enabled; on that edge it wraps back to 0.
//  Ports    : clk, rst (async, active-high), en_i, clr_i (clear wins over
//             enable), tick_o
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int           W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/result_display_ctrl.sv
// ============================================================================
//  Module   : result_display_ctrl
//  Purpose  : Sequential front end for the six seven-segment digit decoders.
//             Tracks inference progress (IDLE/BUSY/SHOW/ERR), latches the
//             predicted class and score, and produces per-digit nibbles and
//             dash flags. Low-confidence results blink the class digit.
//  Ports    : Clk, Reset (async, active-high)
//             bus (slave): start_i, result_valid_i, result_class_i,
//             result_score_i, clear_i -> digit_nib_o, digit_dash_o,
//             busy_o, timeout_o (all outputs registered)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_display_ctrl
    import display_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 50_000_000,
    parameter int          BLINK_CYCLES   = 12_500_000,
    parameter logic [15:0] CONF_THRESH    = 16'h4000
) (
    input  logic                   Clk,
    input  logic                   Reset,
    result_display_ctrl_if.slave   bus
);

    state_t                  state_q, state_d;
    logic [3:0]              class_q, class_d;
    logic [15:0]             score_q, score_d;
    logic                    phase_q, phase_d;
    logic [4*NUM_DIGITS-1:0] nib_q, nib_d;
    logic [NUM_DIGITS-1:0]   dash_q, dash_d;
    logic                    busy_q, busy_d;
    logic                    tmo_q, tmo_d;

    logic to_tick;
    logic blink_tick;
    logic low_conf;
    logic latch_en;

    assign low_conf = (score_q < CONF_THRESH);

    // Timeout counter is held at zero outside BUSY, and a start (entry into
    // BUSY or restart while already busy) zeroes it as well.
    tick_counter #(.N(TIMEOUT_CYCLES)) u_timeout (
        .clk    (Clk),
        .rst    (Reset),
        .en_i   (state_q == BUSY),
        .clr_i  (bus.clear_i || bus.start_i || (state_q != BUSY)),
        .tick_o (to_tick)
    );

    // Held at zero outside SHOW, so entering SHOW always starts from zero.
    tick_counter #(.N(BLINK_CYCLES)) u_blink (
        .clk    (Clk),
        .rst    (Reset),
        .en_i   ((state_q == SHOW) && low_conf),
        .clr_i  (state_q != SHOW),
        .tick_o (blink_tick)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            class_q <= '0;
            score_q <= '0;
            phase_q <= 1'b0;
            nib_q   <= '0;
            dash_q  <= '1;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            score_q <= score_d;
            phase_q <= phase_d;
            nib_q   <= nib_d;
            dash_q  <= dash_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    // ----------------------------------------------------------- next state
    // A result is only taken in BUSY when neither clear nor start is present.
    assign latch_en = !bus.clear_i && !bus.start_i && (state_q == BUSY) &&
                      bus.result_valid_i && (bus.result_class_i <= MAX_CLASS);

    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = IDLE;
        end else if (bus.start_i) begin
            state_d = BUSY;
        end else if (state_q == BUSY) begin
            // A valid result in the timeout cycle takes precedence.
            if (bus.result_valid_i) begin
                state_d = (bus.result_class_i <= MAX_CLASS) ? SHOW : ERR;
            end else if (to_tick) begin
                state_d = ERR;
            end
        end
    end

    always_comb begin
        class_d = class_q;
        score_d = score_q;
        if (latch_en) begin
            class_d = bus.result_class_i;
            score_d = bus.result_score_i;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if ((state_q != SHOW) || !low_conf) begin
            phase_d = 1'b0;
        end else if (blink_tick) begin
            phase_d = ~phase_q;
        end
    end

    // --------------------------------------------------------------- output
    always_comb begin
        nib_d  = '0;
        dash_d = '1;
        busy_d = 1'b0;
        tmo_d  = 1'b0;
        case (state_q)
            BUSY: begin
                busy_d = 1'b1;
            end
            SHOW: begin
                nib_d  = {class_q, 4'h0, score_q};
                dash_d = {phase_q, 1'b1, 4'b0000};
            end
            ERR: begin
                nib_d  = {NIB_ERR, 20'h0_0000};
                dash_d = {1'b0, {(NUM_DIGITS-1){1'b1}}};
                tmo_d  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.digit_nib_o  = nib_q;
    assign bus.digit_dash_o = dash_q;
    assign bus.busy_o       = busy_q;
    assign bus.timeout_o    = tmo_q;

endmodule

`default_nettype wire
